box_slave: RTL and testbench

Downstream AXI write-side receiver that consumes the address and data channels driven by `box_master` over `axi_if`. It accepts one AW request, collects the W beats of that burst, reassembles them into a `spec_slot`, and presents the slot on a valid/ready output toward the receiving slot memory. It also returns a B-channel write response. One burst is in flight at a time.

---
 rtl/box_slave_pkg.sv | 31 +++
 rtl/axi_if.sv | 29 ++
 rtl/box_slave.sv | 104 ++++++++++
 tb/tb_box_slave.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/box_slave_pkg.sv
// Shared sizing, slot layout and FSM encoding for the AXI write-side slot receiver.
package box_slave_pkg;

  localparam int PDATA_WIDTH   = 32;
  localparam int PLENGTH_WIDTH = 4;
  localparam int PSTRB_WIDTH   = PDATA_WIDTH / 8;
  localparam int PMAX_BEATS    = 2 ** PLENGTH_WIDTH;
  localparam int PID_WIDTH     = 4;
  localparam int PADDR_WIDTH   = 32;
  localparam int PUSER_WIDTH   = 8;
  localparam int POTHER_WIDTH  = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    DONE
  } slave_state_e;

  typedef struct packed {
    logic [PID_WIDTH-1:0]                awid;
    logic [PADDR_WIDTH-1:0]              awaddr;
    logic [PLENGTH_WIDTH-1:0]            awlen;
    logic [2:0]                          awsize;
    logic [1:0]                          awburst;
    logic [PUSER_WIDTH-1:0]              awuser;
    logic [POTHER_WIDTH-1:0]             other;
    logic [PMAX_BEATS*PDATA_WIDTH-1:0]   data;
    logic [PMAX_BEATS*PSTRB_WIDTH-1:0]   strb;
  } spec_slot;

endpackage

// File: rtl/axi_if.sv
// AXI write address/data channel bundle shared by box_master and box_slave.
interface axi_if;
  import box_slave_pkg::*;

  logic                     awvalid;
  logic                     awready;
  logic [PID_WIDTH-1:0]     awid;
  logic [PADDR_WIDTH-1:0]   awaddr;
  logic [PLENGTH_WIDTH-1:0] awlen;
  logic [2:0]               awsize;
  logic [1:0]               awburst;
  logic [PUSER_WIDTH-1:0]   awuser;
  logic [POTHER_WIDTH-1:0]  other;

  logic                     wvalid;
  logic                     wready;
  logic [PDATA_WIDTH-1:0]   wdata;
  logic [PSTRB_WIDTH-1:0]   wstrb;
  logic [PID_WIDTH-1:0]     wid;
  logic                     wlast;

  modport master_add (output awvalid, awid, awaddr, awlen, awsize, awburst, awuser, other,
                      input  awready);
  modport slave_add  (input  awvalid, awid, awaddr, awlen, awsize, awburst, awuser, other,
                      output awready);
  modport master_data(output wvalid, wdata, wstrb, wid, wlast, input wready);
  modport slave_data (input  wvalid, wdata, wstrb, wid, wlast, output wready);

endinterface

// File: rtl/box_slave.sv
// Receives one AXI write burst at a time, reassembles its beats into a spec_slot
// and hands it downstream while returning the matching B response.
module box_slave
  import box_slave_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  axi_if.slave_add             s_add,
  axi_if.slave_data            s_data,
  output logic                 bvalid,
  output logic [PID_WIDTH-1:0] bid,
  output logic [1:0]           bresp,
  input  logic                 bready,
  output logic                 out_valid,
  output spec_slot             out_slot,
  input  logic                 out_ready
);

  slave_state_e             state, state_nxt;
  logic [PLENGTH_WIDTH-1:0] cnt;
  logic [PLENGTH_WIDTH-1:0] beat_idx;
  logic [PLENGTH_WIDTH-1:0] cur_len;
  logic [PID_WIDTH-1:0]     cur_id;
  logic                     err;
  logic                     aw_hs, w_hs;
  logic                     last_beat, beat_err;
  logic                     out_free, b_free;

  // In IDLE a beat can only ride along with AW, so it is checked against the
  // incoming address fields rather than the latched ones.
  assign s_add.awready = (state == IDLE);
  assign s_data.wready = (state == IDLE) ? s_add.awvalid : (state == DATA);

  assign aw_hs     = s_add.awvalid && (state == IDLE);
  assign w_hs      = s_data.wvalid && ((state == IDLE) ? s_add.awvalid : (state == DATA));
  assign cur_id    = (state == IDLE) ? s_add.awid  : out_slot.awid;
  assign cur_len   = (state == IDLE) ? s_add.awlen : out_slot.awlen;
  assign beat_idx  = (state == IDLE) ? '0 : cnt;
  assign last_beat = (beat_idx == cur_len);
  assign beat_err  = (s_data.wid != cur_id) || (s_data.wlast && !last_beat);
  assign out_free  = !out_valid || out_ready;
  assign b_free    = !bvalid || bready;

  assign bid   = out_slot.awid;
  assign bresp = {err, 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (aw_hs) state_nxt = (w_hs && last_beat) ? DONE : DATA;
      DATA:    if (w_hs && last_beat) state_nxt = DONE;
      DONE:    if (out_free && b_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      err       <= 1'b0;
      out_slot  <= '0;
      out_valid <= 1'b0;
      bvalid    <= 1'b0;
    end else begin
      if (aw_hs) begin
        out_slot.awid    <= s_add.awid;
        out_slot.awaddr  <= s_add.awaddr;
        out_slot.awlen   <= s_add.awlen;
        out_slot.awsize  <= s_add.awsize;
        out_slot.awburst <= s_add.awburst;
        out_slot.awuser  <= s_add.awuser;
        out_slot.other   <= s_add.other;
        out_slot.data    <= '0;
        out_slot.strb    <= '0;
        err              <= 1'b0;
        cnt              <= '0;
      end
      // Later slice writes override the clear above when beat 0 rides with AW.
      if (w_hs) begin
        for (int i = 0; i < PMAX_BEATS; i++) begin
          if (beat_idx == PLENGTH_WIDTH'(i)) begin
            out_slot.data[i*PDATA_WIDTH +: PDATA_WIDTH] <= s_data.wdata;
            out_slot.strb[i*PSTRB_WIDTH +: PSTRB_WIDTH] <= s_data.wstrb;
          end
        end
        err <= beat_err || (err && !aw_hs);
        cnt <= last_beat ? '0 : beat_idx + PLENGTH_WIDTH'(1);
      end
      if (state != DONE && state_nxt == DONE) begin
        out_valid <= 1'b1;
        bvalid    <= 1'b1;
      end else begin
        if (out_ready) out_valid <= 1'b0;
        if (bready)    bvalid    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_box_slave.sv
// Bench for box_slave: directed burst table, hand sequences and random bursts vs a beat-list model.
module tb_box_slave;
  import box_slave_pkg::*;

  localparam int SW = $bits(spec_slot);
  localparam int DW = PMAX_BEATS * PDATA_WIDTH;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 bvalid, out_valid;
  logic [PID_WIDTH-1:0] bid;
  logic [1:0]           bresp;
  logic                 bready = 1'b0;
  logic                 out_ready = 1'b0;
  spec_slot             out_slot;

  axi_if bus();

  box_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_add    (bus),
    .s_data   (bus),
    .bvalid   (bvalid),
    .bid      (bid),
    .bresp    (bresp),
    .bready   (bready),
    .out_valid(out_valid),
    .out_slot (out_slot),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_fail   = 0;
  string cur_tag  = "init";

  // Burst description consumed by run_burst and by the model
  logic [PID_WIDTH-1:0]     aw_id;
  logic [PADDR_WIDTH-1:0]   aw_addr;
  logic [PLENGTH_WIDTH-1:0] aw_len;
  logic [2:0]               aw_size;
  logic [1:0]               aw_burst;
  logic [PUSER_WIDTH-1:0]   aw_user;
  logic [POTHER_WIDTH-1:0]  aw_other;
  logic [PDATA_WIDTH-1:0]   b_data [PMAX_BEATS];
  logic [PSTRB_WIDTH-1:0]   b_strb [PMAX_BEATS];
  logic [PID_WIDTH-1:0]     b_id   [PMAX_BEATS];
  logic                     b_last [PMAX_BEATS];
  int                       b_gap  [PMAX_BEATS];

  typedef struct {
    logic [PID_WIDTH-1:0]     id;
    logic [31:0]              addr;
    logic [PLENGTH_WIDTH-1:0] len;
    logic [31:0]              base;
    logic [31:0]              step;
    int                       bad_id_beat;
    int                       early_last_beat;
    bit                       final_last;
    bit                       aw_with_w;
    int                       gap_beat;
    int                       dly_o;
    int                       dly_b;
    logic [1:0]               exp_resp;
    logic [127:0]             exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s/%s: got %0h, expected %0h", cur_tag, name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.awsize = '0; bus.awburst = '0; bus.awuser = '0; bus.other = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wid = '0; bus.wlast = 1'b0;
  endtask

  task automatic put_beat(input int i);
    bus.wvalid = 1'b1;
    bus.wdata  = b_data[i];
    bus.wstrb  = b_strb[i];
    bus.wid    = b_id[i];
    bus.wlast  = b_last[i];
  endtask

  // Expected slot: address fields plus the burst's beats laid end to end, rest zero
  function automatic spec_slot model_slot();
    spec_slot s;
    s = '0;
    s.awid = aw_id; s.awaddr = aw_addr; s.awlen = aw_len; s.awsize = aw_size;
    s.awburst = aw_burst; s.awuser = aw_user; s.other = aw_other;
    for (int i = 0; i <= int'(aw_len); i++) begin
      s.data[i*PDATA_WIDTH +: PDATA_WIDTH] = b_data[i];
      s.strb[i*PSTRB_WIDTH +: PSTRB_WIDTH] = b_strb[i];
    end
    return s;
  endfunction

  function automatic logic [1:0] model_resp();
    bit e = 0;
    for (int i = 0; i <= int'(aw_len); i++) begin
      if (b_id[i] != aw_id) e = 1;
      if (b_last[i] && i != int'(aw_len)) e = 1;
    end
    return e ? 2'b10 : 2'b00;
  endfunction

  task automatic run_burst(input bit aw_with_w, input bit held_off, input int dly_o,
                           input int dly_b, output int cyc);
    spec_slot   exp;
    logic [1:0] exp_resp;
    int         last_c;
    exp      = model_slot();
    exp_resp = model_resp();
    cyc      = 0;
    if (!aw_with_w && held_off) begin
      bus.awvalid = 1'b0;
      put_beat(0);
      #1;
      check("w held off", SW'(bus.wready), SW'(0));
      tick();
    end
    bus.awvalid = 1'b1; bus.awid = aw_id; bus.awaddr = aw_addr; bus.awlen = aw_len;
    bus.awsize = aw_size; bus.awburst = aw_burst; bus.awuser = aw_user; bus.other = aw_other;
    if (aw_with_w) put_beat(0);
    else bus.wvalid = 1'b0;
    #1;
    check("awready idle", SW'(bus.awready), SW'(1));
    check("wready follows awvalid", SW'(bus.wready), SW'(1));
    tick();
    cyc++;
    bus.awvalid = 1'b0;
    for (int beat = (aw_with_w ? 1 : 0); beat <= int'(aw_len); beat++) begin
      check("busy out_valid", SW'(out_valid), SW'(0));
      check("busy awready", SW'(bus.awready), SW'(0));
      for (int g = 0; g < b_gap[beat]; g++) begin
        bus.wvalid = 1'b0;
        bus.wdata  = $urandom;
        tick();
        cyc++;
        check("gap out_valid", SW'(out_valid), SW'(0));
      end
      put_beat(beat);
      #1;
      check("wready data", SW'(bus.wready), SW'(1));
      tick();
      cyc++;
    end
    bus.wvalid = 1'b0;
    last_c = (dly_o > dly_b) ? dly_o : dly_b;
    for (int c = 0; c <= last_c; c++) begin
      out_ready   = (c >= dly_o);
      bready      = (c >= dly_b);
      bus.awvalid = 1'($urandom_range(0, 1));
      bus.awid    = PID_WIDTH'($urandom);
      bus.awaddr  = $urandom;
      bus.wvalid  = 1'($urandom_range(0, 1));
      #1;
      check("out_valid done", SW'(out_valid), SW'(c <= dly_o));
      check("bvalid done", SW'(bvalid), SW'(c <= dly_b));
      check("awready done", SW'(bus.awready), SW'(0));
      check("wready done", SW'(bus.wready), SW'(0));
      check("slot", SW'(out_slot), SW'(exp));
      check("bid", SW'(bid), SW'(aw_id));
      check("bresp", SW'(bresp), SW'(exp_resp));
      tick();
    end
    drive_idle();
    out_ready = 1'b0;
    bready    = 1'b0;
    #1;
    check("back to idle", SW'(bus.awready), SW'(1));
    check("valids low", SW'({out_valid, bvalid}), SW'(0));
    check("slot held", SW'(out_slot), SW'(exp));
  endtask

  task automatic load_vec(input vec_t v);
    aw_id = v.id; aw_addr = v.addr; aw_len = v.len;
    aw_size = 3'd2; aw_burst = 2'b01; aw_user = 8'h5A; aw_other = PUSER_WIDTH'(v.len) ^ 8'h3C;
    for (int i = 0; i < PMAX_BEATS; i++) begin
      b_data[i] = v.base + 32'(i) * v.step;
      b_strb[i] = PSTRB_WIDTH'(i + 5);
      b_id[i]   = (i == v.bad_id_beat) ? (v.id ^ PID_WIDTH'(1)) : v.id;
      b_last[i] = (i == int'(v.len)) ? v.final_last : (i == v.early_last_beat);
      b_gap[i]  = (i == v.gap_beat) ? 1 : 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   cyc;

    vecs[0] = '{4'd3, 32'h100, 4'd0, 32'hA5A5A5A5, 32'h0, -1, -1, 1'b0, 1'b1, -1, 0, 0,
                2'b00, 128'hA5A5A5A5};
    vecs[1] = '{4'd5, 32'h200, 4'd3, 32'h11, 32'h11, -1, -1, 1'b1, 1'b1, 2, 0, 0,
                2'b00, 128'h00000044_00000033_00000022_00000011};
    vecs[2] = '{4'd1, 32'h300, 4'd2, 32'h1, 32'h1, -1, 1, 1'b1, 1'b1, -1, 0, 0,
                2'b10, 128'h00000003_00000002_00000001};
    vecs[3] = '{4'd2, 32'h400, 4'd2, 32'h100, 32'h100, 0, -1, 1'b1, 1'b1, -1, 0, 0,
                2'b10, 128'h00000300_00000200_00000100};
    vecs[4] = '{4'd7, 32'h500, 4'd1, 32'hDEAD0000, 32'h1, -1, -1, 1'b1, 1'b1, -1, 3, 0,
                2'b00, 128'hDEAD0001_DEAD0000};
    vecs[5] = '{4'd9, 32'h1000, 4'd15, 32'h01010101, 32'h01010101, -1, -1, 1'b1, 1'b1, -1, 0, 0,
                2'b00, 128'h04040404_03030303_02020202_01010101};
    vecs[6] = '{4'd4, 32'h600, 4'd1, 32'hCAFE0000, 32'h10, -1, -1, 1'b1, 1'b0, -1, 0, 2,
                2'b00, 128'hCAFE0010_CAFE0000};

    drive_idle();
    cur_tag = "reset";
    tick();
    tick();
    check("awready", SW'(bus.awready), SW'(1));
    check("wready", SW'(bus.wready), SW'(0));
    check("bvalid", SW'(bvalid), SW'(0));
    check("bid", SW'(bid), SW'(0));
    check("bresp", SW'(bresp), SW'(0));
    check("out_valid", SW'(out_valid), SW'(0));
    check("out_slot", SW'(out_slot), SW'(0));
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      cur_tag = $sformatf("vec%0d", k);
      load_vec(vecs[k]);
      run_burst(vecs[k].aw_with_w, !vecs[k].aw_with_w, vecs[k].dly_o, vecs[k].dly_b, cyc);
      check("data lo", SW'(out_slot.data[127:0]), SW'(vecs[k].exp_lo));
      check("bresp table", SW'(model_resp()), SW'(vecs[k].exp_resp));
      if (vecs[k].gap_beat < 0 && vecs[k].aw_with_w)
        check("latency", SW'(cyc), SW'(int'(vecs[k].len) + 1));
      else
        check("latency gap", SW'(cyc), SW'(int'(vecs[k].len) + 2));
    end

    cur_tag = "reset mid-burst";
    load_vec('{4'd6, 32'h700, 4'd3, 32'h77770000, 32'h1, -1, -1, 1'b1, 1'b1, -1, 0, 0,
               2'b00, 128'h0});
    bus.awvalid = 1'b1; bus.awid = aw_id; bus.awaddr = aw_addr; bus.awlen = aw_len;
    put_beat(0);
    tick();
    bus.awvalid = 1'b0;
    put_beat(1);
    tick();
    drive_idle();
    #2;
    rst_n = 1'b0;
    #1;
    check("awready", SW'(bus.awready), SW'(1));
    check("valids", SW'({out_valid, bvalid}), SW'(0));
    check("bid bresp", SW'({bid, bresp}), SW'(0));
    check("out_slot", SW'(out_slot), SW'(0));
    tick();
    rst_n = 1'b1;
    tick();
    aw_len = '0; aw_id = 4'd8; aw_addr = 32'h800;
    b_data[0] = 32'h0BADF00D; b_id[0] = 4'd8; b_last[0] = 1'b1; b_gap[0] = 0;
    run_burst(1'b1, 1'b0, 0, 0, cyc);
    check("no stale beats", SW'(out_slot.data[DW-1:PDATA_WIDTH]), SW'(0));
    check("beat0", SW'(out_slot.data[PDATA_WIDTH-1:0]), SW'(32'h0BADF00D));

    for (int r = 0; r < 24; r++) begin
      bit with_w;
      cur_tag = $sformatf("rand%0d", r);
      aw_id = PID_WIDTH'($urandom); aw_addr = $urandom; aw_len = PLENGTH_WIDTH'($urandom_range(0, 15));
      aw_size = 3'($urandom); aw_burst = 2'($urandom); aw_user = PUSER_WIDTH'($urandom);
      aw_other = POTHER_WIDTH'($urandom);
      for (int i = 0; i < PMAX_BEATS; i++) begin
        b_data[i] = $urandom;
        b_strb[i] = PSTRB_WIDTH'($urandom);
        b_id[i]   = ($urandom_range(0, 7) == 0) ? PID_WIDTH'($urandom) : aw_id;
        b_last[i] = (i == int'(aw_len)) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
        b_gap[i]  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      end
      with_w = 1'($urandom_range(0, 1));
      run_burst(with_w, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), cyc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
